// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing a single-port 32x8 synchronous memory between two
// valid/ready requesters; memory pins and responses are registered.
module mem_rr_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              write,
   output logic              read,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] data_out,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT_RD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              write_q, write_d;
   logic              read_q, read_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_in_q, data_in_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              rsp0_valid_q, rsp0_valid_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
   logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
   logic              busy_q, busy_d;
   logic              winner_s;
   logic              any_valid_s;
   logic              ready0_s, ready1_s;

   // Next-state, arbitration and registered-pin computation
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      read_d       = read_q;
      addr_d       = addr_q;
      data_in_d    = data_in_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
      rsp0_rdata_d = rsp0_rdata_q;
      rsp1_rdata_d = rsp1_rdata_q;
      ready0_s     = 1'b0;
      ready1_s     = 1'b0;
      any_valid_s  = req0_valid | req1_valid;
      // On a tie the requester that did not win last time goes next.
      if (req0_valid && req1_valid) begin
         winner_s = ~last_grant_q;
      end else if (req1_valid) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            write_d = 1'b0;
            read_d  = 1'b0;
            if (any_valid_s) begin
               ready0_s     = ~winner_s;
               ready1_s     = winner_s;
               addr_d       = winner_s ? req1_addr  : req0_addr;
               data_in_d    = winner_s ? req1_wdata : req0_wdata;
               write_d      = winner_s ? req1_write : req0_write;
               read_d       = winner_s ? ~req1_write : ~req0_write;
               owner_d      = winner_s;
               last_grant_d = winner_s;
               state_d      = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            write_d = 1'b0;
            read_d  = 1'b0;
            if (write_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT_RD;
            end
         end
         S_WAIT_RD: begin
            if (owner_q) begin
               rsp1_valid_d = 1'b1;
               rsp1_rdata_d = data_out;
            end else begin
               rsp0_valid_d = 1'b1;
               rsp0_rdata_d = data_out;
            end
            state_d = S_IDLE;
         end
         default: begin
            write_d = 1'b0;
            read_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         write_q      <= 1'b0;
         read_q       <= 1'b0;
         addr_q       <= '0;
         data_in_q    <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         read_q       <= read_d;
         addr_q       <= addr_d;
         data_in_q    <= data_in_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_rdata_q <= rsp0_rdata_d;
         rsp1_rdata_q <= rsp1_rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign req0_ready = ready0_s;
   assign req1_ready = ready1_s;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_rdata = rsp0_rdata_q;
   assign rsp1_rdata = rsp1_rdata_q;
   assign write      = write_q;
   assign read       = read_q;
   assign addr       = addr_q;
   assign data_in    = data_in_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural 32x8 synchronous memory.
module tb_mem_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req0_write = 1'b0;
   logic [4:0] req0_addr = 5'd0;
   logic [7:0] req0_wdata = 8'd0;
   logic       req0_ready, rsp0_valid;
   logic [7:0] rsp0_rdata;
   logic       req1_valid = 1'b0, req1_write = 1'b0;
   logic [4:0] req1_addr = 5'd0;
   logic [7:0] req1_wdata = 8'd0;
   logic       req1_ready, rsp1_valid;
   logic [7:0] rsp1_rdata;
   logic       write, read, busy;
   logic [4:0] addr;
   logic [7:0] data_in;
   logic [7:0] data_out = 8'd0;
   logic [7:0] mem [32];

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic       req;
      logic       wr;
      logic [4:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[8];

   mem_rr_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .write(write), .read(read), .addr(addr), .data_in(data_in),
      .data_out(data_out), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory model: write and read act on the edge closing the strobe cycle
   always @(posedge clk) begin
      if (write) mem[addr] <= data_in;
      if (read) data_out <= mem[addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // One complete operation from ready through strobe (and response for reads).
   task automatic do_op(input logic r, input logic w, input logic [4:0] a,
                        input logic [7:0] d, input logic [7:0] exp, input string tag);
      int   n;
      logic rdy, ordy;
      @(negedge clk);
      if (r) begin
         req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
      end else begin
         req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
      end
      n = 0;
      #1;
      rdy = r ? req1_ready : req0_ready;
      while (!rdy && n < 20) begin
         @(negedge clk); #1;
         rdy = r ? req1_ready : req0_ready;
         n++;
      end
      ordy = r ? req0_ready : req1_ready;
      chk({tag, " ready"}, {31'd0, rdy}, 32'd1);
      chk({tag, " other ready"}, {31'd0, ordy}, 32'd0);
      @(posedge clk); #1;
      if (r) req1_valid = 1'b0; else req0_valid = 1'b0;
      chk({tag, " write strobe"}, {31'd0, write}, {31'd0, w});
      chk({tag, " read strobe"}, {31'd0, read}, {31'd0, ~w});
      chk({tag, " addr"}, {27'd0, addr}, {27'd0, a});
      if (w) chk({tag, " data_in"}, {24'd0, data_in}, {24'd0, d});
      @(posedge clk); #1;
      chk({tag, " strobes low"}, {30'd0, write, read}, 32'd0);
      chk({tag, " no early rsp"}, {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      if (!w) begin
         @(posedge clk); #1;
         chk({tag, " rsp valid"}, {30'd0, rsp1_valid, rsp0_valid}, r ? 32'd2 : 32'd1);
         chk({tag, " rdata"}, {24'd0, r ? rsp1_rdata : rsp0_rdata}, {24'd0, exp});
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int   g[$];
      logic exp_rdy;
      for (int i = 0; i < 32; i++) mem[i] = 8'd0;
      vecs[0] = '{req: 1'b0, wr: 1'b1, addr: 5'd5,  wdata: 8'hA5, exp: 8'h00};
      vecs[1] = '{req: 1'b0, wr: 1'b0, addr: 5'd5,  wdata: 8'h00, exp: 8'hA5};
      vecs[2] = '{req: 1'b1, wr: 1'b1, addr: 5'd10, wdata: 8'h5A, exp: 8'h00};
      vecs[3] = '{req: 1'b1, wr: 1'b0, addr: 5'd10, wdata: 8'h00, exp: 8'h5A};
      vecs[4] = '{req: 1'b0, wr: 1'b0, addr: 5'd10, wdata: 8'h00, exp: 8'h5A};
      vecs[5] = '{req: 1'b1, wr: 1'b1, addr: 5'd31, wdata: 8'hFF, exp: 8'h00};
      vecs[6] = '{req: 1'b0, wr: 1'b0, addr: 5'd31, wdata: 8'h00, exp: 8'hFF};
      vecs[7] = '{req: 1'b1, wr: 1'b0, addr: 5'd5,  wdata: 8'h00, exp: 8'hA5};

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset strobes", {30'd0, write, read}, 32'd0);
      chk("reset addr", {27'd0, addr}, 32'd0);
      chk("reset data_in", {24'd0, data_in}, 32'd0);
      chk("reset rsp valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      chk("reset rdata", {16'd0, rsp0_rdata, rsp1_rdata}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;

      // Simultaneous write(req0)/read(req1) right after reset: req0 wins
      @(negedge clk);
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 5'd3; req0_wdata = 8'h3C;
      req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 5'd3;
      #1;
      chk("tie ready0", {31'd0, req0_ready}, 32'd1);
      chk("tie ready1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      chk("tie write", {31'd0, write}, 32'd1);
      chk("tie data_in", {24'd0, data_in}, 32'h3C);
      @(posedge clk); #1;
      chk("tie ready1 second", {31'd0, req1_ready}, 32'd1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      chk("tie read", {31'd0, read}, 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("tie rsp1 valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
      chk("tie rsp1 rdata", {24'd0, rsp1_rdata}, 32'h3C);

      // Table-driven single operations
      for (int k = 0; k < 8; k++) do_op(vecs[k].req, vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].exp, "vec");

      // Fill, read back, clear, read back
      for (int i = 0; i < 32; i++) do_op(1'b0, 1'b1, 5'(i), 8'(i), 8'd0, "fill");
      for (int i = 0; i < 32; i++) do_op(1'b1, 1'b0, 5'(i), 8'd0, 8'(i), "readback");
      for (int i = 0; i < 32; i++) do_op(1'b0, 1'b1, 5'(i), 8'd0, 8'd0, "clear");
      for (int i = 0; i < 32; i++) do_op(1'b1, 1'b0, 5'(i), 8'd0, 8'd0, "readclr");

      // Both requesters continuously valid: grants must alternate from req0
      @(negedge clk);
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 5'd20; req0_wdata = 8'h11;
      req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 5'd21; req1_wdata = 8'h22;
      for (int c = 0; c < 20; c++) begin
         #1;
         chk("alt single grant", {31'd0, req0_ready & req1_ready}, 32'd0);
         if (req0_ready) g.push_back(0);
         if (req1_ready) g.push_back(1);
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("alt grant count", g.size(), 32'd10);
      for (int k = 0; k < g.size(); k++) chk("alt grant order", g[k], k % 2);
      repeat (2) @(negedge clk);

      // Back-to-back req1 reads: ready every third cycle
      do_op(1'b0, 1'b1, 5'd7, 8'h77, 8'd0, "b2b setup");
      @(negedge clk);
      req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 5'd7;
      for (int c = 0; c < 15; c++) begin
         #1;
         exp_rdy = (c % 3 == 0);
         chk("b2b ready1", {31'd0, req1_ready}, {31'd0, exp_rdy});
         if (!exp_rdy) chk("b2b busy", {31'd0, busy}, 32'd1);
         chk("b2b rsp0 quiet", {31'd0, rsp0_valid}, 32'd0);
         chk("b2b rsp1 valid", {31'd0, rsp1_valid}, {31'd0, exp_rdy && c > 0});
         if (rsp1_valid) chk("b2b rdata", {24'd0, rsp1_rdata}, 32'h77);
         if (c == 14) req1_valid = 1'b0;
         @(negedge clk);
      end
      #1;
      chk("b2b last rsp", {31'd0, rsp1_valid}, 32'd1);
      chk("b2b last rdata", {24'd0, rsp1_rdata}, 32'h77);

      // Reset while a read is waiting for data
      @(negedge clk);
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 5'd7;
      #1;
      chk("rstmid ready0", {31'd0, req0_ready}, 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rstmid strobes", {30'd0, write, read}, 32'd0);
      chk("rstmid busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("rstmid no rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
         @(negedge clk);
      end
      chk("rstmid rdata cleared", {24'd0, rsp0_rdata}, 32'd0);
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 5'd7;
      req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 5'd7;
      #1;
      chk("rstmid tie ready0", {31'd0, req0_ready}, 32'd1);
      chk("rstmid tie ready1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
